pipeline_ctrl: RTL and testbench
================================

Name: pipeline_ctrl

Overview:
- Parametrised pipeline sequencer for the multicore MIPS datapath.
- Replaces the single global regEN/flush pair, which today drives every pipeline latch identically.
- Generates a per-latch enable and flush vector, the PC enable, and per-latch valid bits.
- Also handles load-use stalls, branch squash, memory wait, halt drain and a stall performance counter.

Parameters:
NLATCH, 4, number of pipeline latches (FD, DE, EM, MW for 5 stages); minimum 3.
EX_IDX, 1, latch index feeding EX (the DE latch); the branch and load source.
MEM_IDX, 2, latch index feeding MEM (the EM latch).
REGW, 5, register-select width.
STALLW, 16, stall counter width.

Ports:
CLK  in  1  clock
RST  in  1  reset, asynchronous, active-high
ihit  in  1  instruction fetch complete this cycle
dhit  in  1  data access complete this cycle
mem_req  in  1  instruction in MEM has dcuREN or dcuWEN set
ex_is_load  in  1  instruction in EX has memtoreg==1
ex_wsel  in  REGW  destination register of the instruction in EX
id_rs  in  REGW  rs of the instruction in ID
id_rt  in  REGW  rt of the instruction in ID
id_uses_rt  in  1  ID instruction reads rt
branch_taken  in  1  EX has resolved a taken branch or jump
halt_dec  in  1  ID has decoded a halt
stage_en  out  NLATCH  per-latch load enable
stage_flush  out  NLATCH  per-latch clear (bubble insert); takes priority over enable inside the latch
pc_en  out  1  PC update enable
valid  out  NLATCH  latch holds a real instruction
halt_out  out  1  sticky halted flag
stall_cnt  out  STALLW  cycles with pc_en==0 while in RUN

Behaviour:
- Clock and reset: single clock CLK; RST is asynchronous, active-high.
- While RST is high:
  - valid=0, state=RUN, drain counter=0, halt_out=0, stall_cnt=0.
  - Combinational outputs are forced to stage_en=0, stage_flush=all ones, pc_en=0.
  - Reset asserted mid-stall or mid-drain discards everything; the first cycle after release is a clean RUN.
- Conditions, evaluated each cycle:
  - mem_wait = valid[MEM_IDX] & mem_req & ~dhit
  - load_use = valid[EX_IDX] & valid[0] & ex_is_load & ex_wsel!=0 & (ex_wsel==id_rs | (id_uses_rt & ex_wsel==id_rt))
  - br = valid[EX_IDX] & branch_taken
- RUN state: the first condition that holds, in this order, sets the outputs.
  - mem_wait: stage_en=0, stage_flush=0, pc_en=0. Whole pipe frozen; every other condition is ignored.
  - br: stage_en=all ones, stage_flush[0]=stage_flush[1]=1, pc_en=1. Kills the IF and ID instructions. Wins over load_use and ~ihit; any outstanding fetch is abandoned.
  - load_use: stage_en[0]=0 (FD held), stage_flush[EX_IDX]=1 (bubble into EX), latches above EX_IDX enabled, pc_en=0.
  - ~ihit: stage_en=all ones, stage_flush[0]=1, pc_en=0.
  - otherwise: all enabled, no flush, pc_en=1.
- Valid tracking:
  - On a clock edge, a latch whose flush is set gets valid[i]=0.
  - Otherwise a latch whose enable is set gets valid[i]=valid[i-1].
  - For latch 0 the incoming valid is ihit & (state==RUN).
  - Disabled latches hold their valid bit.
- Halt FSM, states RUN, DRAIN, HALTED:
  - RUN -> DRAIN: halt_dec & valid[0], with none of mem_wait, br or load_use holding. The drain counter loads NLATCH.
  - A halt that is squashed by br does not take effect.
  - DRAIN: pc_en=0; stage_flush[0]=1; latches enabled except on mem_wait, which freezes everything as in RUN. The counter decrements only on non-frozen cycles. br and load_use are ignored in DRAIN.
  - DRAIN -> HALTED: when the counter reaches 0, i.e. after exactly NLATCH advancing cycles.
  - HALTED: stage_en=0, pc_en=0, halt_out=1. Stays there until RST.
- stall_cnt:
  - Increments on every RUN cycle with pc_en=0; saturates at all ones.
  - Holds in DRAIN and HALTED.
- Latency: all outputs except valid, halt_out and stall_cnt are combinational from inputs and state. valid, halt_out and stall_cnt are registered.

Decomposition:
- Package pipe_ctrl_pkg:
  - ctrl_state_t enum {RUN, DRAIN, HALTED}.
  - Default latch-index constants FD_IDX=0, DE_IDX=1, EM_IDX=2, MW_IDX=3.
- Sub-module hazard_detect: purely combinational; computes load_use from the register selects. Instanced once.

Test Plan:
- Reset release, ihit=1 held, no hazards -> valid fills 0001, 0011, 0111, 1111 over four cycles; pc_en=1 every cycle; stall_cnt=0.
- lw $3 in EX (ex_wsel=3, ex_is_load=1), ID has id_rs=3 -> one cycle of stage_en=1110, stage_flush=0010, pc_en=0; next cycle normal; stall_cnt=1.
- branch_taken=1 with ihit=0 and load_use true simultaneously -> stage_flush=0011, pc_en=1, stage_en=1111; valid[1:0] become 0 next cycle.
- mem_req=1, dhit=0 for 3 cycles, then dhit=1 -> stage_en=0 and pc_en=0 for 3 cycles; valid unchanged; advance on the 4th cycle; stall_cnt=3.
- halt_dec in ID, with a 2-cycle mem_wait during drain -> halt_out rises exactly NLATCH+2=6 cycles after the DRAIN entry edge; stage_en=0 afterwards; RST pulse mid-DRAIN returns to RUN with valid=0.
- Hold ihit=0 for 2^STALLW+5 cycles -> stall_cnt saturates at 16'hFFFF, no wrap.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pipe_ctrl_pkg;

  // Sequencer modes: normal flow, draining after a halt, fully stopped.
  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } ctrl_state_t;

  // Default latch positions for the classic 5-stage MIPS pipe.
  localparam int FD_IDX = 0;
  localparam int DE_IDX = 1;
  localparam int EM_IDX = 2;
  localparam int MW_IDX = 3;

  // Width needed for a down-counter that starts at n.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Hazard inputs from the datapath and per-latch controls back to it.
// Latency: n/a (wiring only).
// Backpressure: ihit/dhit are the only stall sources; controls carry no handshake.
interface pipeline_ctrl_if #(
  parameter int NLATCH = 4,
  parameter int REGW   = 5,
  parameter int STALLW = 16
);
  logic              ihit;
  logic              dhit;
  logic              mem_req;
  logic              ex_is_load;
  logic [REGW-1:0]   ex_wsel;
  logic [REGW-1:0]   id_rs;
  logic [REGW-1:0]   id_rt;
  logic              id_uses_rt;
  logic              branch_taken;
  logic              halt_dec;
  logic [NLATCH-1:0] stage_en;
  logic [NLATCH-1:0] stage_flush;
  logic              pc_en;
  logic [NLATCH-1:0] valid;
  logic              halt_out;
  logic [STALLW-1:0] stall_cnt;

  // Datapath side: reports hazards, consumes latch controls.
  modport master (
    output ihit, dhit, mem_req, ex_is_load, ex_wsel, id_rs, id_rt,
           id_uses_rt, branch_taken, halt_dec,
    input  stage_en, stage_flush, pc_en, valid, halt_out, stall_cnt
  );

  // Sequencer side.
  modport slave (
    input  ihit, dhit, mem_req, ex_is_load, ex_wsel, id_rs, id_rt,
           id_uses_rt, branch_taken, halt_dec,
    output stage_en, stage_flush, pc_en, valid, halt_out, stall_cnt
  );
endinterface

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use hazard: a load in EX writes a register the ID instruction reads.
// Latency: combinational.
// Backpressure: none; result feeds the sequencer priority logic.
module hazard_detect #(
  parameter int REGW = 5
) (
  input  logic            ex_vld,
  input  logic            id_vld,
  input  logic            ex_is_load,
  input  logic [REGW-1:0] ex_wsel,
  input  logic [REGW-1:0] id_rs,
  input  logic [REGW-1:0] id_rt,
  input  logic            id_uses_rt,
  output logic            load_use
);

  // $0 is never a real dependency; rt only matters when ID actually reads it.
  assign load_use = ex_vld & id_vld & ex_is_load & (ex_wsel != '0) &
                    ((ex_wsel == id_rs) | (id_uses_rt & (ex_wsel == id_rt)));

endmodule

// File: rtl/pipeline_ctrl.sv
// Per-latch enable/flush, PC enable, valid tracking, halt drain and stall counter.
// Latency: enables/flushes/pc_en combinational; valid, halt_out, stall_cnt registered.
// Backpressure: a pending data access freezes the whole pipe; fetch miss bubbles ID.
module pipeline_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int NLATCH  = 4,
  parameter int EX_IDX  = DE_IDX,
  parameter int MEM_IDX = EM_IDX,
  parameter int REGW    = 5,
  parameter int STALLW  = 16
) (
  input logic           CLK,
  input logic           RST,
  pipeline_ctrl_if.slave bus
);

  localparam int CNTW = cnt_width(NLATCH);
  localparam logic [NLATCH-1:0] ALL   = '1;
  localparam logic [NLATCH-1:0] ONE   = NLATCH'(1);
  localparam logic [NLATCH-1:0] LU_EN = ALL << EX_IDX;
  localparam logic [NLATCH-1:0] LU_FL = ONE << EX_IDX;
  localparam logic [NLATCH-1:0] BR_FL = NLATCH'(3);

  ctrl_state_t       state, state_nxt;
  logic [CNTW-1:0]   cnt, cnt_nxt;
  logic [NLATCH-1:0] valid_q, en, fl, vin;
  logic              pc;
  logic              halt_q;
  logic [STALLW-1:0] stall_q;
  logic              mem_wait, br, load_use, halt_go;

  assign mem_wait = valid_q[MEM_IDX] & bus.mem_req & ~bus.dhit;
  assign br       = valid_q[EX_IDX] & bus.branch_taken;

  hazard_detect #(.REGW(REGW)) u_hazard (
    .ex_vld     (valid_q[EX_IDX]),
    .id_vld     (valid_q[FD_IDX]),
    .ex_is_load (bus.ex_is_load),
    .ex_wsel    (bus.ex_wsel),
    .id_rs      (bus.id_rs),
    .id_rt      (bus.id_rt),
    .id_uses_rt (bus.id_uses_rt),
    .load_use   (load_use)
  );

  // A halt only commits when ID actually advances this cycle.
  assign halt_go = bus.halt_dec & valid_q[FD_IDX] & ~mem_wait & ~br & ~load_use;

  // Latch 0 only picks up a real instruction while still fetching.
  assign vin = {valid_q[NLATCH-2:0], bus.ihit & (state == RUN)};

  // Priority-encoded latch controls and halt FSM next state.
  always_comb begin
    en        = '0;
    fl        = '0;
    pc        = 1'b0;
    state_nxt = state;
    cnt_nxt   = cnt;
    if (RST) begin
      fl = ALL;
    end else begin
      case (state)
        RUN: begin
          if (mem_wait) begin
            en = '0;
          end else if (br) begin
            en = ALL;
            fl = BR_FL;
            pc = 1'b1;
          end else if (load_use) begin
            en = LU_EN;
            fl = LU_FL;
          end else if (!bus.ihit) begin
            en = ALL;
            fl = ONE;
          end else begin
            en = ALL;
            pc = 1'b1;
          end
          if (halt_go) begin
            state_nxt = DRAIN;
            cnt_nxt   = CNTW'(NLATCH);
          end
        end
        DRAIN: begin
          if (!mem_wait) begin
            en      = ALL;
            fl      = ONE;
            cnt_nxt = cnt - CNTW'(1);
            if (cnt == CNTW'(1)) state_nxt = HALTED;
          end
        end
        HALTED: begin
          en = '0;
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  // State, drain counter and sticky halt flag.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state  <= RUN;
      cnt    <= '0;
      halt_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      halt_q <= (state_nxt == HALTED);
    end
  end

  // Valid bits follow their latch: flush clears, enable shifts, else hold.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) valid_q <= '0;
    else     valid_q <= ((valid_q & ~en) | (vin & en)) & ~fl;
  end

  // Saturating count of RUN cycles where the PC did not advance.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                                          stall_q <= '0;
    else if (state == RUN && !pc && stall_q != '1)    stall_q <= stall_q + STALLW'(1);
  end

  assign bus.stage_en    = en;
  assign bus.stage_flush = fl;
  assign bus.pc_en       = pc;
  assign bus.valid       = valid_q;
  assign bus.halt_out    = halt_q;
  assign bus.stall_cnt   = stall_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios plus random traffic.
// Latency: n/a.
// Backpressure: n/a.
module tb_pipeline_ctrl;
  localparam int NL = 4, EXI = 1, MEMI = 2, RW = 5, SW = 16;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  pipeline_ctrl_if #(.NLATCH(NL), .REGW(RW), .STALLW(SW)) bus ();
  pipeline_ctrl #(.NLATCH(NL), .EX_IDX(EXI), .MEM_IDX(MEMI), .REGW(RW), .STALLW(SW))
    dut (.CLK(CLK), .RST(RST), .bus(bus));

  int checks = 0;
  int errors = 0;

  // Reference model: mode 0=running, 1=draining, 2=stopped.
  bit [NL-1:0] m_valid;
  int          m_mode, m_left, m_stall;
  bit          m_halt;

  typedef struct packed {
    logic [NL-1:0] en;
    logic [NL-1:0] fl;
    logic          pc;
  } exp_t;

  function automatic void conds(output bit mw, output bit lu, output bit br);
    mw = m_valid[MEMI] && bus.mem_req && !bus.dhit;
    br = m_valid[EXI] && bus.branch_taken;
    lu = m_valid[EXI] && m_valid[0] && bus.ex_is_load && bus.ex_wsel != 0 &&
         (bus.ex_wsel == bus.id_rs || (bus.id_uses_rt && bus.ex_wsel == bus.id_rt));
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    bit mw, lu, br;
    conds(mw, lu, br);
    e = '0;
    if (m_mode == 0) begin
      if (mw)              e = '0;
      else if (br)         begin e.en = 4'b1111; e.fl = 4'b0011; e.pc = 1'b1; end
      else if (lu)         begin e.en = 4'b1111 << EXI; e.fl = 4'b0001 << EXI; end
      else if (!bus.ihit)  begin e.en = 4'b1111; e.fl = 4'b0001; end
      else                 begin e.en = 4'b1111; e.pc = 1'b1; end
    end else if (m_mode == 1 && !mw) begin
      e.en = 4'b1111; e.fl = 4'b0001;
    end
    return e;
  endfunction

  task automatic model_clock();
    exp_t e;
    bit mw, lu, br;
    bit [NL-1:0] up, nv;
    e = model_out();
    conds(mw, lu, br);
    up = {m_valid[NL-2:0], bus.ihit && m_mode == 0};
    for (int i = 0; i < NL; i++)
      nv[i] = e.fl[i] ? 1'b0 : (e.en[i] ? up[i] : m_valid[i]);
    if (m_mode == 0 && !e.pc && m_stall < 65535) m_stall++;
    if (m_mode == 0 && bus.halt_dec && m_valid[0] && !mw && !br && !lu) begin
      m_mode = 1; m_left = NL;
    end else if (m_mode == 1 && !mw) begin
      m_left--;
      if (m_left == 0) m_mode = 2;
    end
    m_halt  = (m_mode == 2);
    m_valid = nv;
  endtask

  task automatic set_idle();
    bus.ihit = 1'b1; bus.dhit = 1'b1; bus.mem_req = 1'b0; bus.ex_is_load = 1'b0;
    bus.ex_wsel = '0; bus.id_rs = '0; bus.id_rt = '0; bus.id_uses_rt = 1'b0;
    bus.branch_taken = 1'b0; bus.halt_dec = 1'b0;
  endtask

  task automatic advance();
    model_clock();
    @(posedge CLK); #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    set_idle();
    m_valid = '0; m_mode = 0; m_left = 0; m_halt = 1'b0; m_stall = 0;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
  endtask

  task automatic fill();
    do_reset();
    repeat (4) advance();
  endtask

  task automatic test_reset();
    set_idle();
    @(posedge CLK); #3;
    checks++; if (bus.stage_en !== 4'b0000) begin errors++; $display("FAIL rst_en got %b want 0000", bus.stage_en); end
    checks++; if (bus.stage_flush !== 4'b1111) begin errors++; $display("FAIL rst_flush got %b want 1111", bus.stage_flush); end
    checks++; if (bus.pc_en !== 1'b0) begin errors++; $display("FAIL rst_pc got %b want 0", bus.pc_en); end
    checks++; if (bus.valid !== 4'b0000) begin errors++; $display("FAIL rst_valid got %b want 0000", bus.valid); end
    checks++; if (bus.halt_out !== 1'b0) begin errors++; $display("FAIL rst_halt got %b want 0", bus.halt_out); end
    checks++; if (bus.stall_cnt !== 16'h0) begin errors++; $display("FAIL rst_stall got %h want 0", bus.stall_cnt); end
  endtask

  task automatic test_fill();
    logic [NL-1:0] want;
    do_reset();
    #2;
    checks++; if (bus.pc_en !== 1'b1) begin errors++; $display("FAIL fill_pc0 got %b want 1", bus.pc_en); end
    for (int k = 1; k <= NL; k++) begin
      advance(); #2;
      want = NL'((1 << k) - 1);
      checks++; if (bus.valid !== want) begin errors++; $display("FAIL fill_valid%0d got %b want %b", k, bus.valid, want); end
      checks++; if (bus.pc_en !== 1'b1) begin errors++; $display("FAIL fill_pc%0d got %b want 1", k, bus.pc_en); end
    end
    checks++; if (bus.stall_cnt !== 16'h0) begin errors++; $display("FAIL fill_stall got %h want 0", bus.stall_cnt); end
  endtask

  task automatic test_load_use();
    fill();
    bus.ex_is_load = 1'b1; bus.ex_wsel = 5'd3; bus.id_rs = 5'd3; #2;
    checks++; if (bus.stage_en !== 4'b1110) begin errors++; $display("FAIL lu_en got %b want 1110", bus.stage_en); end
    checks++; if (bus.stage_flush !== 4'b0010) begin errors++; $display("FAIL lu_flush got %b want 0010", bus.stage_flush); end
    checks++; if (bus.pc_en !== 1'b0) begin errors++; $display("FAIL lu_pc got %b want 0", bus.pc_en); end
    advance();
    bus.ex_is_load = 1'b0; #2;
    checks++; if (bus.valid !== 4'b1101) begin errors++; $display("FAIL lu_valid got %b want 1101", bus.valid); end
    checks++; if (bus.pc_en !== 1'b1 || bus.stage_flush !== 4'b0000) begin errors++; $display("FAIL lu_next got pc=%b fl=%b want pc=1 fl=0000", bus.pc_en, bus.stage_flush); end
    checks++; if (bus.stall_cnt !== 16'd1) begin errors++; $display("FAIL lu_stall got %0d want 1", bus.stall_cnt); end
  endtask

  task automatic test_branch();
    fill();
    bus.ex_is_load = 1'b1; bus.ex_wsel = 5'd7; bus.id_rt = 5'd7; bus.id_uses_rt = 1'b1;
    bus.ihit = 1'b0; bus.branch_taken = 1'b1; bus.halt_dec = 1'b1; #2;
    checks++; if (bus.stage_flush !== 4'b0011) begin errors++; $display("FAIL br_flush got %b want 0011", bus.stage_flush); end
    checks++; if (bus.stage_en !== 4'b1111) begin errors++; $display("FAIL br_en got %b want 1111", bus.stage_en); end
    checks++; if (bus.pc_en !== 1'b1) begin errors++; $display("FAIL br_pc got %b want 1", bus.pc_en); end
    advance();
    set_idle(); #2;
    checks++; if (bus.valid !== 4'b1100) begin errors++; $display("FAIL br_valid got %b want 1100", bus.valid); end
    checks++; if (bus.pc_en !== 1'b1) begin errors++; $display("FAIL br_halt_squashed got pc=%b want 1", bus.pc_en); end
  endtask

  task automatic test_mem_wait();
    fill();
    bus.mem_req = 1'b1; bus.dhit = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #2;
      checks++; if (bus.stage_en !== 4'b0000 || bus.pc_en !== 1'b0) begin errors++; $display("FAIL mw_freeze%0d got en=%b pc=%b want en=0000 pc=0", k, bus.stage_en, bus.pc_en); end
      advance();
      checks++; if (bus.valid !== 4'b1111) begin errors++; $display("FAIL mw_valid%0d got %b want 1111", k, bus.valid); end
    end
    bus.dhit = 1'b1; #2;
    checks++; if (bus.stage_en !== 4'b1111 || bus.pc_en !== 1'b1) begin errors++; $display("FAIL mw_release got en=%b pc=%b want en=1111 pc=1", bus.stage_en, bus.pc_en); end
    advance();
    checks++; if (bus.stall_cnt !== 16'd3) begin errors++; $display("FAIL mw_stall got %0d want 3", bus.stall_cnt); end
  endtask

  task automatic test_halt_drain();
    logic want;
    fill();
    bus.halt_dec = 1'b1; #2;
    advance();
    bus.halt_dec = 1'b0; #2;
    checks++; if (bus.pc_en !== 1'b0 || bus.stage_flush !== 4'b0001 || bus.stage_en !== 4'b1111) begin errors++; $display("FAIL drain_out got en=%b fl=%b pc=%b want 1111/0001/0", bus.stage_en, bus.stage_flush, bus.pc_en); end
    for (int k = 1; k <= NL + 2; k++) begin
      bus.mem_req = (k == 2 || k == 3); bus.dhit = 1'b0; #2;
      advance();
      want = (k == NL + 2);
      checks++; if (bus.halt_out !== want) begin errors++; $display("FAIL drain_halt%0d got %b want %b", k, bus.halt_out, want); end
    end
    set_idle(); #2;
    checks++; if (bus.stage_en !== 4'b0000 || bus.pc_en !== 1'b0) begin errors++; $display("FAIL halted_out got en=%b pc=%b want 0000/0", bus.stage_en, bus.pc_en); end
    checks++; if (bus.stall_cnt !== 16'd0) begin errors++; $display("FAIL drain_stall got %0d want 0", bus.stall_cnt); end
    // Reset in the middle of a drain.
    fill();
    bus.halt_dec = 1'b1; #2;
    advance();
    bus.halt_dec = 1'b0;
    repeat (2) advance();
    #2 RST = 1'b1; #1;
    checks++; if (bus.stage_en !== 4'b0000 || bus.stage_flush !== 4'b1111) begin errors++; $display("FAIL mid_rst_out got en=%b fl=%b want 0000/1111", bus.stage_en, bus.stage_flush); end
    do_reset(); #2;
    checks++; if (bus.valid !== 4'b0000 || bus.pc_en !== 1'b1) begin errors++; $display("FAIL mid_rst_run got valid=%b pc=%b want 0000/1", bus.valid, bus.pc_en); end
    repeat (NL + 2) advance();
    checks++; if (bus.halt_out !== 1'b0) begin errors++; $display("FAIL mid_rst_halt got %b want 0", bus.halt_out); end
  endtask

  task automatic test_random();
    exp_t e;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if (c % 500 == 499) do_reset();
      bus.ihit         = ($urandom_range(0, 3) != 0);
      bus.dhit         = ($urandom_range(0, 2) != 0);
      bus.mem_req      = 1'($urandom_range(0, 1));
      bus.ex_is_load   = 1'($urandom_range(0, 1));
      bus.ex_wsel      = 5'($urandom_range(0, 3));
      bus.id_rs        = 5'($urandom_range(0, 3));
      bus.id_rt        = 5'($urandom_range(0, 3));
      bus.id_uses_rt   = 1'($urandom_range(0, 1));
      bus.branch_taken = ($urandom_range(0, 7) == 0);
      bus.halt_dec     = ($urandom_range(0, 40) == 0);
      #2;
      e = model_out();
      checks++; if (bus.stage_en !== e.en) begin errors++; $display("FAIL rnd_en c=%0d got %b want %b", c, bus.stage_en, e.en); end
      checks++; if (bus.stage_flush !== e.fl) begin errors++; $display("FAIL rnd_flush c=%0d got %b want %b", c, bus.stage_flush, e.fl); end
      checks++; if (bus.pc_en !== e.pc) begin errors++; $display("FAIL rnd_pc c=%0d got %b want %b", c, bus.pc_en, e.pc); end
      checks++; if (bus.valid !== m_valid) begin errors++; $display("FAIL rnd_valid c=%0d got %b want %b", c, bus.valid, m_valid); end
      checks++; if (bus.halt_out !== m_halt) begin errors++; $display("FAIL rnd_halt c=%0d got %b want %b", c, bus.halt_out, m_halt); end
      checks++; if (bus.stall_cnt !== 16'(m_stall)) begin errors++; $display("FAIL rnd_stall c=%0d got %0d want %0d", c, bus.stall_cnt, m_stall); end
      advance();
    end
  endtask

  task automatic test_saturate();
    do_reset();
    bus.ihit = 1'b0;
    repeat (65534) @(posedge CLK);
    #1;
    checks++; if (bus.stall_cnt !== 16'hFFFE) begin errors++; $display("FAIL sat_pre got %h want fffe", bus.stall_cnt); end
    repeat (7) @(posedge CLK);
    #1;
    checks++; if (bus.stall_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_hold got %h want ffff", bus.stall_cnt); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_load_use();
    test_branch();
    test_mem_wait();
    test_halt_drain();
    test_random();
    test_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
